// File: rtl/camac_pkg.sv
// Shared types and helpers for the CAMAC dataway master.
package camac_pkg;

  typedef enum logic [1:0] {
    KIND_NAF  = 2'd0,
    KIND_C    = 2'd1,
    KIND_Z    = 2'd2,
    KIND_RSVD = 2'd3
  } cmd_kind_e;

  localparam logic [1:0] FCLASS_READ  = 2'b00;
  localparam logic [1:0] FCLASS_WRITE = 2'b10;
  localparam logic [4:0] STATION_MAX  = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE1,
    ST_GAP,
    ST_STROBE2,
    ST_HOLD,
    ST_RESP
  } state_e;

  function automatic logic is_read(input logic [4:0] f);
    return f[4:3] == FCLASS_READ;
  endfunction

  function automatic logic is_write(input logic [4:0] f);
    return f[4:3] == FCLASS_WRITE;
  endfunction

  function automatic int max_t(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/camac_phase_timer.sv
// Loadable down-counter shared by every dataway phase; done while the count is zero.
module camac_phase_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/camac_dataway_master.sv
// CAMAC crate-controller dataway master: one command -> one timed N.A.F / C / Z cycle -> one response.
// IDLE: accepting | SETUP: lines valid | STROBE1: S1 | GAP | STROBE2: S2 | HOLD: lines held | RESP: response
module camac_dataway_master
  import camac_pkg::*;
#(
  parameter int T_SETUP = 10,
  parameter int T_S1    = 10,
  parameter int T_GAP   = 10,
  parameter int T_S2    = 10,
  parameter int T_HOLD  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_kind,
  input  logic [4:0]  cmd_n,
  input  logic [3:0]  cmd_a,
  input  logic [4:0]  cmd_f,
  input  logic [23:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_rdata,
  output logic        rsp_q,
  output logic        rsp_x,
  output logic        rsp_err,
  output logic [4:0]  camac_n,
  output logic [3:0]  camac_a,
  output logic [4:0]  camac_f,
  output logic [23:0] camac_w,
  output logic        camac_b,
  output logic        camac_s1,
  output logic        camac_s2,
  output logic        camac_c,
  output logic        camac_z,
  input  logic [23:0] camac_r,
  input  logic        camac_q,
  input  logic        camac_x
);

  localparam int T_MAX = max_t(max_t(max_t(T_SETUP, T_S1), max_t(T_GAP, T_S2)), T_HOLD);
  localparam int CW    = $clog2(T_MAX) + 1;

  state_e      state_q, state_d;
  cmd_kind_e   kind_q, kind_d;
  logic [4:0]  n_q, n_d, f_q, f_d;
  logic [3:0]  a_q, a_d;
  logic [23:0] w_q, w_d, rdata_q, rdata_d;
  logic        q_q, q_d, x_q, x_d, err_q, err_d;
  logic        timer_load, timer_done, reject;
  logic [CW-1:0] timer_val;

  camac_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign reject = (cmd_kind == KIND_RSVD) ||
                  ((cmd_kind == KIND_NAF) && ((cmd_n == 5'd0) || (cmd_n > STATION_MAX)));

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    n_d        = n_q;
    a_d        = a_q;
    f_d        = f_q;
    w_d        = w_q;
    rdata_d    = rdata_q;
    q_d        = q_q;
    x_d        = x_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          kind_d  = cmd_kind_e'(cmd_kind);
          n_d     = cmd_n;
          a_d     = cmd_a;
          f_d     = cmd_f;
          w_d     = cmd_wdata;
          rdata_d = '0;
          q_d     = 1'b0;
          x_d     = 1'b0;
          err_d   = reject;
          if (reject) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_SETUP;
            timer_load = 1'b1;
            timer_val  = CW'(T_SETUP - 1);
          end
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          timer_load = 1'b1;
          // C and Z cycles carry no S1 strobe
          if (kind_q == KIND_NAF) begin
            state_d   = ST_STROBE1;
            timer_val = CW'(T_S1 - 1);
          end else begin
            state_d   = ST_GAP;
            timer_val = CW'(T_GAP - 1);
          end
        end
      end
      ST_STROBE1: begin
        if (timer_done) begin
          rdata_d    = is_read(f_q) ? camac_r : '0;
          q_d        = camac_q;
          x_d        = camac_x;
          state_d    = ST_GAP;
          timer_load = 1'b1;
          timer_val  = CW'(T_GAP - 1);
        end
      end
      ST_GAP: begin
        if (timer_done) begin
          state_d    = ST_STROBE2;
          timer_load = 1'b1;
          timer_val  = CW'(T_S2 - 1);
        end
      end
      ST_STROBE2: begin
        if (timer_done) begin
          state_d    = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = CW'(T_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (timer_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_NAF;
      n_q     <= '0;
      a_q     <= '0;
      f_q     <= '0;
      w_q     <= '0;
      rdata_q <= '0;
      q_q     <= 1'b0;
      x_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      n_q     <= n_d;
      a_q     <= a_d;
      f_q     <= f_d;
      w_q     <= w_d;
      rdata_q <= rdata_d;
      q_q     <= q_d;
      x_q     <= x_d;
      err_q   <= err_d;
    end
  end

  logic busy, naf;
  assign busy = (state_q == ST_SETUP) || (state_q == ST_STROBE1) || (state_q == ST_GAP) ||
                (state_q == ST_STROBE2) || (state_q == ST_HOLD);
  assign naf  = busy && (kind_q == KIND_NAF);

  // Held low during reset so every output reads 0 while rst is asserted
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_q     = q_q;
  assign rsp_x     = x_q;
  assign rsp_err   = err_q;

  assign camac_b  = busy;
  assign camac_n  = naf ? n_q : '0;
  assign camac_a  = naf ? a_q : '0;
  assign camac_f  = naf ? f_q : '0;
  assign camac_w  = (naf && is_write(f_q)) ? w_q : '0;
  assign camac_s1 = (state_q == ST_STROBE1);
  assign camac_s2 = (state_q == ST_STROBE2);
  assign camac_c  = busy && (kind_q == KIND_C);
  assign camac_z  = busy && (kind_q == KIND_Z);

endmodule

// File: tb/tb_camac_dataway_master.sv
// Directed bench for camac_dataway_master with a cycle-offset reference model checked every cycle.
module tb_camac_dataway_master;

  localparam int TS = 10, T1 = 10, TG = 10, T2 = 10, TH = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_kind = '0;
  logic [4:0]  cmd_n = '0;
  logic [3:0]  cmd_a = '0;
  logic [4:0]  cmd_f = '0;
  logic [23:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [23:0] rsp_rdata;
  logic        rsp_q, rsp_x, rsp_err;
  logic [4:0]  camac_n, camac_f;
  logic [3:0]  camac_a;
  logic [23:0] camac_w;
  logic        camac_b, camac_s1, camac_s2, camac_c, camac_z;
  logic [23:0] camac_r = '0;
  logic        camac_q = 1'b0;
  logic        camac_x = 1'b0;

  camac_dataway_master #(
    .T_SETUP(TS), .T_S1(T1), .T_GAP(TG), .T_S2(T2), .T_HOLD(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_n(cmd_n), .cmd_a(cmd_a), .cmd_f(cmd_f), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_q(rsp_q), .rsp_x(rsp_x), .rsp_err(rsp_err),
    .camac_n(camac_n), .camac_a(camac_a), .camac_f(camac_f), .camac_w(camac_w),
    .camac_b(camac_b), .camac_s1(camac_s1), .camac_s2(camac_s2),
    .camac_c(camac_c), .camac_z(camac_z),
    .camac_r(camac_r), .camac_q(camac_q), .camac_x(camac_x)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  bit en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 dataway cycle in progress (m_t = 1-based cycle index), 2 response
  int          m_mode = 0;
  int          m_t = 0;
  logic [1:0]  m_kind = '0;
  logic [4:0]  m_n = '0, m_f = '0;
  logic [3:0]  m_a = '0;
  logic [23:0] m_w = '0, m_rdata = '0;
  logic        m_q = 1'b0, m_x = 1'b0, m_err = 1'b0;

  function automatic bit f_read(input logic [4:0] f);
    return f <= 5'd7;
  endfunction

  function automatic bit f_write(input logic [4:0] f);
    return (f >= 5'd16) && (f <= 5'd23);
  endfunction

  function automatic int busy_len(input logic [1:0] k);
    return (k == 2'd0) ? TS + T1 + TG + T2 + TH : TS + TG + T2 + TH;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
    end else if (m_mode == 0) begin
      if (cmd_valid) begin
        m_kind  <= cmd_kind;
        m_n     <= cmd_n;
        m_a     <= cmd_a;
        m_f     <= cmd_f;
        m_w     <= cmd_wdata;
        m_rdata <= '0;
        m_q     <= 1'b0;
        m_x     <= 1'b0;
        m_t     <= 1;
        if (cmd_kind == 2'd3 || (cmd_kind == 2'd0 && (cmd_n == 5'd0 || cmd_n > 5'd23))) begin
          m_err  <= 1'b1;
          m_mode <= 2;
        end else begin
          m_err  <= 1'b0;
          m_mode <= 1;
        end
      end
    end else if (m_mode == 1) begin
      if (m_kind == 2'd0 && m_t == TS + T1) begin
        m_rdata <= f_read(m_f) ? camac_r : 24'd0;
        m_q     <= camac_q;
        m_x     <= camac_x;
      end
      if (m_t == busy_len(m_kind)) m_mode <= 2;
      else                         m_t <= m_t + 1;
    end else begin
      if (rsp_ready) m_mode <= 0;
    end
  end

  int b_cnt, s1_cnt, s2_cnt, z_cnt, c_cnt, w_cnt, s1_first, nz_cnt, rv_cnt;

  always @(negedge clk) begin
    if (en) begin
      bit busy, naf;
      int s2s;
      busy = (m_mode == 1);
      naf  = busy && (m_kind == 2'd0);
      s2s  = TS + ((m_kind == 2'd0) ? T1 : 0) + TG;
      chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0 && !rst));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_mode == 2));
      chk("camac_b",   32'(camac_b),   32'(busy));
      chk("camac_s1",  32'(camac_s1),  32'(naf && m_t > TS && m_t <= TS + T1));
      chk("camac_s2",  32'(camac_s2),  32'(busy && m_t > s2s && m_t <= s2s + T2));
      chk("camac_c",   32'(camac_c),   32'(busy && m_kind == 2'd1));
      chk("camac_z",   32'(camac_z),   32'(busy && m_kind == 2'd2));
      chk("camac_n",   32'(camac_n),   32'(naf ? m_n : 5'd0));
      chk("camac_a",   32'(camac_a),   32'(naf ? m_a : 4'd0));
      chk("camac_f",   32'(camac_f),   32'(naf ? m_f : 5'd0));
      chk("camac_w",   32'(camac_w),   32'((naf && f_write(m_f)) ? m_w : 24'd0));
      if (m_mode == 2) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("rsp_q",     32'(rsp_q),     32'(m_q));
        chk("rsp_x",     32'(rsp_x),     32'(m_x));
        chk("rsp_err",   32'(rsp_err),   32'(m_err));
      end
      if (camac_b) b_cnt++;
      if (camac_s1) begin
        s1_cnt++;
        if (s1_first == 0) s1_first = cyc - acc + 1;
      end
      if (camac_s2) s2_cnt++;
      if (camac_z) z_cnt++;
      if (camac_c) c_cnt++;
      if (camac_b && camac_w == cmd_wdata && cmd_wdata != 0) w_cnt++;
      if (camac_n != 0 || camac_a != 0 || camac_f != 0 || camac_w != 0) nz_cnt++;
      if (rsp_valid) rv_cnt++;
    end
  end

  task automatic clr_cnt();
    b_cnt = 0; s1_cnt = 0; s2_cnt = 0; z_cnt = 0; c_cnt = 0;
    w_cnt = 0; s1_first = 0; nz_cnt = 0; rv_cnt = 0;
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge (response-offset origin)
  task automatic issue(input logic [1:0] k, input logic [4:0] n, input logic [3:0] a,
                       input logic [4:0] f, input logic [23:0] w);
    int guard;
    guard = 0;
    clr_cnt();
    cmd_kind = k; cmd_n = n; cmd_a = a; cmd_f = f; cmd_wdata = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      acc = cyc;
    end
  endtask

  task automatic wait_rsp(output int off);
    int guard;
    guard = 0;
    while (!rsp_valid && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
    off = cyc - acc + 1;
  endtask

  initial begin
    int off;
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_camac_b",   32'(camac_b),   32'd0);
    chk("rst_camac_w",   32'(camac_w),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // F0 read, N=5 A=2
    camac_r = 24'hABCDEF; camac_q = 1'b1; camac_x = 1'b1;
    issue(2'd0, 5'd5, 4'd2, 5'd0, 24'h0);
    wait_rsp(off);
    chk("f0_rsp_offset", 32'(off), 32'd51);
    chk("f0_rdata", 32'(rsp_rdata), 32'hABCDEF);
    chk("f0_q", 32'(rsp_q), 32'd1);
    chk("f0_x", 32'(rsp_x), 32'd1);
    chk("f0_err", 32'(rsp_err), 32'd0);
    chk("f0_b_cycles", 32'(b_cnt), 32'd50);
    chk("f0_s1_first", 32'(s1_first), 32'd11);
    chk("f0_s1_cycles", 32'(s1_cnt), 32'd10);
    chk("f0_s2_cycles", 32'(s2_cnt), 32'd10);
    @(posedge clk); #1;

    // F16 write
    camac_r = 24'hFFFFFF; camac_q = 1'b0; camac_x = 1'b1;
    issue(2'd0, 5'd7, 4'd1, 5'd16, 24'h123456);
    wait_rsp(off);
    chk("f16_b_cycles", 32'(b_cnt), 32'd50);
    chk("f16_w_cycles", 32'(w_cnt), 32'd50);
    chk("f16_rdata", 32'(rsp_rdata), 32'd0);
    @(posedge clk); #1;

    // Z cycle with stray N/A/F fields that must not reach the dataway
    issue(2'd2, 5'd9, 4'd3, 5'd17, 24'h0000AA);
    wait_rsp(off);
    chk("z_rsp_offset", 32'(off), 32'd41);
    chk("z_b_cycles", 32'(b_cnt), 32'd40);
    chk("z_z_cycles", 32'(z_cnt), 32'd40);
    chk("z_s1_cycles", 32'(s1_cnt), 32'd0);
    chk("z_s2_cycles", 32'(s2_cnt), 32'd10);
    chk("z_naf_lines", 32'(nz_cnt), 32'd0);
    chk("z_q", 32'(rsp_q), 32'd0);
    @(posedge clk); #1;

    // C cycle
    issue(2'd1, 5'd4, 4'd0, 5'd9, 24'h0);
    wait_rsp(off);
    chk("c_c_cycles", 32'(c_cnt), 32'd40);
    chk("c_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;

    // Rejections: N=0, N=24, reserved kind
    issue(2'd0, 5'd0, 4'd0, 5'd0, 24'h0);
    wait_rsp(off);
    chk("rej_n0_offset", 32'(off), 32'd1);
    chk("rej_n0_err", 32'(rsp_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rej_n0_no_busy", 32'(b_cnt), 32'd0);
    issue(2'd0, 5'd24, 4'd0, 5'd0, 24'h0);
    wait_rsp(off);
    chk("rej_n24_err", 32'(rsp_err), 32'd1);
    @(posedge clk); #1;
    issue(2'd3, 5'd5, 4'd0, 5'd0, 24'h0);
    wait_rsp(off);
    chk("rej_kind3_err", 32'(rsp_err), 32'd1);
    chk("rej_kind3_offset", 32'(off), 32'd1);
    @(posedge clk); #1;

    // F24 control at top station: no W, no rdata, Q/X still latched
    camac_r = 24'hFFFFFF; camac_q = 1'b1; camac_x = 1'b0;
    issue(2'd0, 5'd23, 4'd15, 5'd24, 24'h654321);
    wait_rsp(off);
    chk("f24_rdata", 32'(rsp_rdata), 32'd0);
    chk("f24_q", 32'(rsp_q), 32'd1);
    chk("f24_x", 32'(rsp_x), 32'd0);
    chk("f24_w_cycles", 32'(w_cnt), 32'd0);
    @(posedge clk); #1;

    // Response backpressure
    camac_r = 24'h00C0DE; camac_q = 1'b1; camac_x = 1'b1;
    rsp_ready = 1'b0;
    issue(2'd0, 5'd12, 4'd6, 5'd1, 24'h0);
    wait_rsp(off);
    camac_r = 24'h111111; camac_q = 1'b0; camac_x = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rdata", 32'(rsp_rdata), 32'h00C0DE);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(cmd_ready), 32'd1);

    // Back-to-back rejected commands with rsp_ready high
    rv_cnt = 0;
    cmd_kind = 2'd3; cmd_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("b2b_rsp_count", 32'(rv_cnt), 32'd4);
    @(posedge clk); #1;

    // Reset in the middle of STROBE1
    camac_r = 24'h5A5A5A; camac_q = 1'b1; camac_x = 1'b1;
    issue(2'd0, 5'd3, 4'd1, 5'd2, 24'h0);
    repeat (11) @(posedge clk);
    #1;
    chk("mid_in_s1", 32'(camac_s1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_b_low", 32'(camac_b), 32'd0);
    chk("mid_s1_low", 32'(camac_s1), 32'd0);
    chk("mid_n_low", 32'(camac_n), 32'd0);
    rst = 1'b0;
    rv_cnt = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("mid_no_rsp", 32'(rv_cnt), 32'd0);
    issue(2'd0, 5'd3, 4'd1, 5'd2, 24'h0);
    wait_rsp(off);
    chk("post_rst_offset", 32'(off), 32'd51);
    chk("post_rst_b_cycles", 32'(b_cnt), 32'd50);
    chk("post_rst_rdata", 32'(rsp_rdata), 32'h5A5A5A);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camac_dataway_master.md
# camac_dataway_master

Crate-controller side of the CAMAC dataway for the Mössbauer accumulator system. It accepts one command at a time over a valid/ready request port and executes a timed dataway cycle: a normal N·A·F cycle, a Clear (C) cycle or an Initialise (Z) cycle. It drives N, A, F, W, B, S1, S2, C and Z, samples R, Q and X, and returns one response per command. It is the initiator counterpart of the accumulator's CAMAC responder logic, and it sits between the host/sequencer and the dataway pins.

## Interface
Parameters (all in clk cycles, each ≥ 1; defaults give a 1 µs cycle at 50 MHz):
- T_SETUP, 10, N/A/F/W valid before S1
- T_S1, 10, S1 strobe width
- T_GAP, 10, gap between S1 and S2
- T_S2, 10, S2 strobe width
- T_HOLD, 10, lines held after S2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block is idle and accepting a command
- cmd_kind  in  2  0 = NAF, 1 = C, 2 = Z, 3 = reserved
- cmd_n  in  5  station 1..23
- cmd_a  in  4  subaddress
- cmd_f  in  5  function code
- cmd_wdata  in  24  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  24  R lines latched on read functions, else 0
- rsp_q  out  1  latched Q
- rsp_x  out  1  latched X
- rsp_err  out  1  command rejected; no dataway cycle was run
- camac_n  out  5  station code (0 = none)
- camac_a  out  4  subaddress
- camac_f  out  5  function
- camac_w  out  24  write lines
- camac_b  out  1  dataway busy
- camac_s1  out  1  strobe S1
- camac_s2  out  1  strobe S2
- camac_c  out  1  dataway clear
- camac_z  out  1  dataway initialise
- camac_r  in  24  read lines
- camac_q  in  1  Q response
- camac_x  in  1  X (command accepted)

## Operation
- **FSM states:** IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, RESP.
- **Ready:** cmd_ready = 1 only in IDLE.
- **Accept:** a command is taken when cmd_valid & cmd_ready; all cmd_* fields are registered at that edge.
- **Function class:**
  - F[4:3]=00: read (F0–F7).
  - F[4:3]=10: write (F16–F23).
  - Any other value: control.
- **Rejection:** NAF with cmd_n = 0 or cmd_n ≥ 24, or cmd_kind = 3, goes IDLE→RESP directly. Response: rsp_err=1, q=x=0, rdata=0. No dataway line toggles.
- **NAF path:** SETUP→STROBE1→GAP→STROBE2→HOLD→RESP.
  - camac_b, n, a, f held from SETUP through HOLD.
  - camac_w = wdata over the same span for write functions, 0 otherwise.
  - camac_s1 = 1 exactly in STROBE1; camac_s2 = 1 exactly in STROBE2.
  - camac_r, q, x sampled on the last STROBE1 cycle. rsp_rdata = sampled R for read functions, 0 otherwise.
- **C/Z path:** SETUP→GAP→STROBE2→HOLD→RESP, STROBE1 skipped.
  - camac_c or camac_z held with camac_b over the whole span.
  - n, a, f, w stay 0.
  - Response: q=x=0, rdata=0, err=0.
- **RESP:** rsp_valid=1 and all rsp_* stable until rsp_valid & rsp_ready, then IDLE.
- **Phase timing:** each phase lasts exactly its T_* cycles, counted by a down-counter of width $clog2(max T)+1.

## Timing
- **Reset values:** every output 0, FSM = IDLE. cmd_ready = 1 in the first cycle after rst deasserts.
- **Phase start:** acceptance at edge k → SETUP is the state in cycle k+1.
- **Busy length:** camac_b is high for T_SETUP+T_S1+T_GAP+T_S2+T_HOLD cycles (NAF, 50 by default), or T_SETUP+T_GAP+T_S2+T_HOLD (C/Z, 40).
- **Response timing:** rsp_valid rises in the cycle after the last HOLD cycle. It rises 1 cycle after acceptance for a rejected command.
- **Back-to-back:** with rsp_ready tied high, rsp_valid lasts 1 cycle and cmd_ready returns the next cycle. Minimum idle gap between commands is 1 cycle.
- **Dataway inputs:** R, Q and X are ignored outside the sampling cycle.
- **Reset mid-cycle:** all dataway outputs are 0 the cycle after the rst edge, the in-flight response is discarded and no rsp_valid is produced.

## Structure
- **Package camac_pkg:**
  - cmd_kind encodings.
  - Function-class localparams and helpers is_read(f) and is_write(f).
  - Station limit 23.
  - FSM state enum.
- **Sub-module camac_phase_timer:** loadable down-counter with a done pulse, reused for every phase.
- **Top level:** FSM and response registers.

## Test plan
- **F0 read:** F0, N=5, A=2, camac_r=0xABCDEF, q=x=1 → S1 high in cycles k+11..k+20, b high for 50 cycles, rsp_rdata=0xABCDEF, q=1, x=1, err=0.
- **F16 write:** F16 with wdata 0x123456, camac_r=0xFFFFFF → camac_w=0x123456 for all 50 busy cycles, rsp_rdata=0.
- **Z cycle:** kind=2 → camac_z=b=1 for 40 cycles, S1 never high, S2 high 10 cycles, n=a=f=0.
- **Rejected station:** cmd_n=0 with F0 → rsp_valid at k+1 with err=1; camac_b never asserts.
- **Response backpressure:** rsp_ready low for 20 cycles after rsp_valid → rsp_* stable and cmd_ready=0 throughout. Handshake → cmd_ready=1 next cycle.
- **Reset mid-cycle:** rst during STROBE1 → all camac_* = 0 next cycle, no response, and the next command runs a normal full cycle.
